// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one single-port block RAM between a read-only video port and a read/write game port
// Video has fixed priority; a starvation counter forces one game grant after MAX_WAIT lost cycles.
module sram_port_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int MAX_WAIT   = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  vid_req,
  input  logic [ADDR_WIDTH-1:0] vid_addr,
  output logic                  vid_gnt,
  output logic                  vid_rvalid,
  output logic [DATA_WIDTH-1:0] vid_rdata,
  input  logic                  gm_req,
  input  logic                  gm_we,
  input  logic [ADDR_WIDTH-1:0] gm_addr,
  input  logic [DATA_WIDTH-1:0] gm_wdata,
  output logic                  gm_gnt,
  output logic                  gm_rvalid,
  output logic [DATA_WIDTH-1:0] gm_rdata,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout
);
  localparam int CW = $clog2(MAX_WAIT + 1);
  logic [CW-1:0] r_wait_cnt;
  logic          w_force;
  assign w_force   = r_wait_cnt == CW'(MAX_WAIT);
  assign gm_gnt    = ~reset & gm_req & (w_force | ~vid_req);
  assign vid_gnt   = ~reset & vid_req & ~gm_gnt;
  assign ram_en    = vid_gnt | gm_gnt;
  assign ram_we    = gm_gnt & gm_we;
  assign ram_addr  = gm_gnt ? gm_addr : vid_gnt ? vid_addr : '0;
  assign ram_din   = gm_wdata;
  assign vid_rdata = ram_dout;
  assign gm_rdata  = ram_dout;
  // a forced grant always fires at MAX_WAIT, so the counter cannot overrun
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wait_cnt <= '0;
      vid_rvalid <= 1'b0;
      gm_rvalid  <= 1'b0;
    end else begin
      r_wait_cnt <= (~gm_req | gm_gnt) ? '0 : r_wait_cnt + 1'b1;
      vid_rvalid <= vid_gnt;
      gm_rvalid  <= gm_gnt & ~gm_we;
    end
  end
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: directed-vector bench with a behavioural write-first RAM behind the arbiter
module tb_sram_port_arbiter;
  logic        clk = 0;
  logic        reset = 1;
  logic        vid_req = 0, gm_req = 0, gm_we = 0;
  logic [15:0] vid_addr = 0, gm_addr = 0;
  logic [7:0]  gm_wdata = 0;
  logic        vid_gnt, vid_rvalid, gm_gnt, gm_rvalid, ram_en, ram_we;
  logic [7:0]  vid_rdata, gm_rdata, ram_din, ram_dout;
  logic [15:0] ram_addr;
  logic [7:0]  mem [0:65535];
  logic [7:0]  vid_exp [0:3];
  int          n_tests = 0, n_fail = 0;

  sram_port_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(16), .MAX_WAIT(15)) dut (
    .clk(clk), .reset(reset),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_gnt(vid_gnt), .vid_rvalid(vid_rvalid), .vid_rdata(vid_rdata),
    .gm_req(gm_req), .gm_we(gm_we), .gm_addr(gm_addr), .gm_wdata(gm_wdata),
    .gm_gnt(gm_gnt), .gm_rvalid(gm_rvalid), .gm_rdata(gm_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) begin
        mem[ram_addr] <= ram_din;
        ram_dout <= ram_din;
      end else ram_dout <= mem[ram_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vid_exp[0] = 8'h11; vid_exp[1] = 8'h22; vid_exp[2] = 8'h33; vid_exp[3] = 8'h44;
    for (int i = 0; i < 4; i++) mem[i] = vid_exp[i];
    mem[16'h0010] = 8'h00;
    vid_req = 1; gm_req = 1; vid_addr = 16'h0002; gm_addr = 16'h0005;
    tick();
    tick();
    check("rst_vid_gnt", vid_gnt, 0);
    check("rst_gm_gnt", gm_gnt, 0);
    check("rst_ram_en", ram_en, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_vid_rvalid", vid_rvalid, 0);
    check("rst_gm_rvalid", gm_rvalid, 0);
    reset = 0; vid_req = 0; gm_req = 0;
    tick();
    // game write then read back
    gm_req = 1; gm_we = 1; gm_addr = 16'h0010; gm_wdata = 8'hA5;
    #1;
    check("wr_gm_gnt", gm_gnt, 1);
    check("wr_ram_we", ram_we, 1);
    check("wr_ram_en", ram_en, 1);
    check("wr_ram_addr", ram_addr, 16'h0010);
    check("wr_ram_din", ram_din, 8'hA5);
    tick();
    check("wr_gm_rvalid", gm_rvalid, 0);
    gm_we = 0; gm_wdata = 8'h00;
    #1;
    check("rd_gm_gnt", gm_gnt, 1);
    check("rd_ram_we", ram_we, 0);
    tick();
    gm_req = 0;
    check("rd_gm_rvalid", gm_rvalid, 1);
    check("rd_gm_rdata", gm_rdata, 8'hA5);
    tick();
    check("idle_gm_rvalid", gm_rvalid, 0);
    // video streaming reads
    for (int i = 0; i < 4; i++) begin
      vid_req = 1; vid_addr = 16'(i);
      #1;
      check($sformatf("vid_gnt%0d", i), vid_gnt, 1);
      check($sformatf("vid_addr%0d", i), ram_addr, 16'(i));
      check($sformatf("vid_rvalid%0d", i), vid_rvalid, i > 0);
      if (i > 0) check($sformatf("vid_rdata%0d", i), vid_rdata, vid_exp[i-1]);
      tick();
    end
    vid_req = 0;
    check("vid_rvalid4", vid_rvalid, 1);
    check("vid_rdata4", vid_rdata, 8'h44);
    tick();
    check("vid_rvalid_end", vid_rvalid, 0);
    // contention: forced game grant on cycle 16, rvalid on 17
    vid_req = 1; vid_addr = 16'h0001; gm_req = 1; gm_we = 0; gm_addr = 16'h0010;
    for (int c = 1; c <= 17; c++) begin
      #1;
      check($sformatf("cont_gm_gnt%0d", c), gm_gnt, c == 16);
      check($sformatf("cont_vid_gnt%0d", c), vid_gnt, c != 16);
      check($sformatf("cont_gm_rvalid%0d", c), gm_rvalid, c == 17);
      if (c == 16) check("cont_ram_addr16", ram_addr, 16'h0010);
      if (c == 17) check("cont_gm_rdata17", gm_rdata, 8'hA5);
      tick();
    end
    gm_req = 0;
    tick();
    // withdrawal restarts the count
    gm_req = 1;
    for (int c = 1; c <= 5; c++) begin
      #1;
      check($sformatf("wd_pre_gm_gnt%0d", c), gm_gnt, 0);
      tick();
    end
    gm_req = 0;
    #1;
    check("wd_low_gm_gnt", gm_gnt, 0);
    tick();
    gm_req = 1;
    for (int c = 1; c <= 16; c++) begin
      #1;
      check($sformatf("wd_gm_gnt%0d", c), gm_gnt, c == 16);
      tick();
    end
    gm_req = 0;
    tick();
    // reset mid-operation drops pending rvalid
    vid_req = 1;
    #1;
    check("mid_vid_gnt", vid_gnt, 1);
    tick();
    reset = 1;
    #1;
    check("mid_rst_vid_gnt", vid_gnt, 0);
    check("mid_rst_rvalid_before", vid_rvalid, 1);
    tick();
    check("mid_rst_rvalid_after", vid_rvalid, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
